// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner: switch count, default debounce
// and tick-divider lengths, and a counter-width helper.
package input_conditioner_pkg;

  localparam int NUM_SWITCHES        = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_TICK_DIV        = 2097152;

  // Bits needed to hold every value 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One raw input: 2-flop synchronizer, then a stable level that only follows
// the synchronized value after it has held for DEBOUNCE_CYCLES clocks.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable_p2;
  logic [CNT_W-1:0] cnt_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      stable_p2 <= 1'b0;
      cnt_p2    <= '0;
    end else begin
      // synchronizer stages
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // debounce stage: any agreement with the stable level restarts the count
      if (sync_p1 == stable_p2) begin
        cnt_p2 <= '0;
      end else if (cnt_p2 == CNT_LAST) begin
        stable_p2 <= sync_p1;
        cnt_p2    <= '0;
      end else begin
        cnt_p2 <= sat_inc(cnt_p2);
      end
    end
  end

  assign db = stable_p2;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the slide switches and transfer button, and generates the
// periodic tick enable used by downstream logic.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEF_TICK_DIV
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SWITCHES-1:0] switches_raw,
  input  logic                    transfer_raw,
  output logic [NUM_SWITCHES-1:0] switches_db,
  output logic                    transfer_db,
  output logic                    transfer_rise,
  output logic                    tick
);

  localparam int               TICK_W    = cnt_width(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [NUM_SWITCHES:0] raw_all;
  logic [NUM_SWITCHES:0] db_all;
  logic                  transfer_prev_p0;
  logic [TICK_W-1:0]     tick_cnt_p0;

  assign raw_all = {transfer_raw, switches_raw};

  for (genvar i = 0; i <= NUM_SWITCHES; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_all[i]),
      .db   (db_all[i])
    );
  end

  assign switches_db = db_all[NUM_SWITCHES-1:0];
  assign transfer_db = db_all[NUM_SWITCHES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      transfer_prev_p0 <= 1'b0;
      tick_cnt_p0      <= '0;
    end else begin
      // edge-detect and divider stage
      transfer_prev_p0 <= transfer_db;
      tick_cnt_p0      <= (tick_cnt_p0 == TICK_LAST) ? '0 : tick_cnt_p0 + 1'b1;
    end
  end

  assign transfer_rise = transfer_db & ~transfer_prev_p0;
  assign tick          = (tick_cnt_p0 == TICK_LAST);

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive clocks a synchronized input must hold a new level before it is accepted (minimum 2).
REQ-002 Parameter TICK_DIV, default 2097152, clock cycles per tick strobe period (minimum 2).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 switches_raw  input  8  unsynchronized slide-switch levels.
REQ-006 transfer_raw  input  1  unsynchronized transfer push-button level.
REQ-007 switches_db  output  8  synchronized, debounced switch levels.
REQ-008 transfer_db  output  1  synchronized, debounced transfer level.
REQ-009 transfer_rise  output  1  one-clock pulse on each debounced 0->1 transition of transfer.
REQ-010 tick  output  1  one-clock enable strobe, once every TICK_DIV clocks; downstream logic uses it as a clock enable, never as a clock.

Function
REQ-011 Each of the 9 raw inputs SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-012 Each bit SHALL keep a stable register and a saturating counter sized ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-013 A cycle where synchronized value equals stable value SHALL clear that bit's counter.
REQ-014 A cycle where they differ SHALL increment the counter; on the cycle it reaches DEBOUNCE_CYCLES the stable register SHALL take the synchronized value and the counter SHALL clear.
REQ-015 A bounce (return to stable level) before the count completes SHALL clear the counter with no output change.
REQ-016 Latency from a clean raw edge to the debounced output change SHALL be exactly DEBOUNCE_CYCLES+2 clocks.
REQ-017 The 9 bits SHALL debounce independently; simultaneous changes on several bits SHALL each settle on their own count.
REQ-018 transfer_rise SHALL be high in exactly the first cycle transfer_db reads 1 and low otherwise; 1->0 transitions produce no pulse.
REQ-019 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high during the cycle the counter equals TICK_DIV-1.
REQ-020 Tick counter SHALL run unconditionally, unaffected by input activity.

Reset
REQ-021 Asserting reset SHALL immediately clear synchronizers, stable registers, debounce counters and tick counter.
REQ-022 During reset: switches_db=8'h00, transfer_db=0, transfer_rise=0, tick=0.
REQ-023 After deassertion, a raw input held at 1 SHALL appear on its debounced output DEBOUNCE_CYCLES+2 clocks later and, for transfer, SHALL produce one transfer_rise pulse.
REQ-024 Reset asserted mid-count SHALL discard the partial count; no output change SHALL result from pre-reset activity.
REQ-025 First tick after deassertion SHALL occur in the TICK_DIV-th clock cycle.

Structure
REQ-026 Shared package SHALL hold NUM_SWITCHES=8 and the default DEBOUNCE_CYCLES and TICK_DIV values.
REQ-027 One sub-module, debounce_bit (synchronizer + counter + stable register, parameterized by DEBOUNCE_CYCLES), SHALL be instantiated 9 times.
REQ-028 Tick divider and rise detector SHALL live in input_conditioner itself.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-029 Reset, switches_raw=8'hA5 held -> switches_db=8'h00 until 6 clocks after release, then 8'hA5.
REQ-030 transfer_raw toggles 1,0,1,0 every clock then holds 1 -> transfer_db stays 0 until 6 clocks after the final rise, then one transfer_rise pulse.
REQ-031 transfer_raw 0->1, held 20 clocks, then 0 -> exactly one transfer_rise pulse; none on release.
REQ-032 Free run 40 clocks after reset -> tick high on cycles 8,16,24,32,40 only, one clock each.
REQ-033 switches_raw 8'h00->8'hFF, reset pulsed 3 clocks after change -> switches_db 8'h00 through reset, 8'hFF 6 clocks after release.
REQ-034 bit0 and bit7 raised simultaneously, bit7 bounces low for 1 clock after 2 clocks -> bit0 settles after 6 clocks, bit7 after its counter restarts.
